// File: rtl/rob_finish_arbiter_pkg.sv
// Shared constants for the ROB finish-port arbiter.
//   RRF_SEL     : ROB entry address width (default finish address width)
//   ROB_NUM     : number of ROB entries addressable with RRF_SEL bits
//   EX_UNIT_NUM : default number of execution units sharing the finish port
// Also provides the round-robin pointer advance helper used by the top level.
package rob_finish_arbiter_pkg;

  localparam int RRF_SEL     = 6;
  localparam int ROB_NUM     = 1 << RRF_SEL;
  localparam int EX_UNIT_NUM = 4;

  // Default ROB entry address type.
  typedef logic [RRF_SEL-1:0] rob_addr_t;

  // Pointer that follows a winner: one past it, wrapping to 0 after the last requester.
  function automatic int rr_advance(input int winner, input int num_req);
    return (winner >= num_req - 1) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/rob_finish_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter.
//   req       in  NUM_REQ  request vector (valid holding slots)
//   rr_ptr    in  ID_W     index where the search starts
//   grant     out NUM_REQ  one-hot grant, zero when nothing requests
//   grant_idx out ID_W     binary index of the winner (0 when no grant)
//   grant_any out 1        any requester won
// The search visits rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first requester found wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] idx;
  int              idx_int;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    idx_int   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Modulo keeps the search inside 0..NUM_REQ-1 even for non power-of-two counts.
      idx_int = (int'(rr_ptr) + k) % NUM_REQ;
      idx     = idx_int[ID_W-1:0];
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_finish_arbiter.sv
// Shares the ROB's single finish-write port between NUM_REQ execution units.
// Each unit hands one completion per handshake into a private holding slot; a round-robin
// arbiter drains one slot per cycle into a registered finish output. Flush drops all pending.
//   clk_i         in   1               clock
//   reset_ni      in   1               asynchronous active-low reset
//   req_valid_i   in   NUM_REQ         unit i has a completion
//   req_addr_i    in   NUM_REQ*ADDR_W  ROB address of unit i, slice [i*ADDR_W +: ADDR_W]
//   req_ready_o   out  NUM_REQ         unit i's slot accepts this cycle
//   flush_i       in   1               drop everything pending, accept nothing
//   finish_o      out  1               to ROB: mark entry finished
//   finish_addr_o out  ADDR_W          to ROB: entry to mark
//   grant_id_o    out  ID_W            requester behind the current finish_o
//   busy_o        out  1               any holding slot valid
module rob_finish_arbiter
  import rob_finish_arbiter_pkg::*;
#(
  parameter int NUM_REQ = EX_UNIT_NUM,
  parameter int ADDR_W  = RRF_SEL,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      flush_i,
  output logic                      finish_o,
  output logic [ADDR_W-1:0]         finish_addr_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      busy_o
);

  logic [NUM_REQ-1:0] hold_vld;
  logic [ADDR_W-1:0]  hold_addr [NUM_REQ];
  logic [ADDR_W-1:0]  in_addr   [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               grant_fire;
  logic [NUM_REQ-1:0] accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign in_addr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (hold_vld),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A flush suppresses the grant so nothing is delivered and the pointer does not move.
  assign grant_fire = grant_any & ~flush_i;

  // Ready depends only on registered state, flush and reset: a slot being drained this
  // cycle can be refilled at the same edge, giving one completion per cycle per unit.
  assign req_ready_o = {NUM_REQ{reset_ni & ~flush_i}} & (~hold_vld | grant);
  assign accept      = req_valid_i & req_ready_o;
  assign busy_o      = |hold_vld;

  // Holding slots: an accept at the same edge as the grant wins, so the slot stays valid.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hold_vld <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_addr[i] <= '0;
      end
    end else if (flush_i) begin
      hold_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          hold_vld[i]  <= 1'b1;
          hold_addr[i] <= in_addr[i];
        end else if (grant[i]) begin
          hold_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer: moves one past the winner only when a grant is delivered.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= ID_W'(rr_advance(int'(grant_idx), NUM_REQ));
    end
  end

  // Registered finish port; address and id keep their last value when idle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      finish_o      <= 1'b0;
      finish_addr_o <= '0;
      grant_id_o    <= '0;
    end else begin
      finish_o <= grant_fire;
      if (grant_fire) begin
        finish_addr_o <= hold_addr[grant_idx];
        grant_id_o    <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rob_finish_arbiter.sv
// Directed testbench for rob_finish_arbiter with a scoreboard of expected finishes
// (address, requester id) filled as stimulus is loaded and popped on every finish_o.
module tb_rob_finish_arbiter;
  import rob_finish_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int IW = 2;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic [N-1:0]    req_valid_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N-1:0]    req_ready_o;
  logic            flush_i;
  logic            finish_o;
  logic [AW-1:0]   finish_addr_o;
  logic [IW-1:0]   grant_id_o;
  logic            busy_o;

  rob_finish_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .req_valid_i   (req_valid_i),
    .req_addr_i    (req_addr_i),
    .req_ready_o   (req_ready_o),
    .flush_i       (flush_i),
    .finish_o      (finish_o),
    .finish_addr_o (finish_addr_o),
    .grant_id_o    (grant_id_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Per-unit source queues: a unit keeps presenting its head entry until accepted.
  logic [AW-1:0]    src_addr [N][16];
  int               src_head [N];
  int               src_cnt  [N];
  logic [AW+IW-1:0] exp_q [$];
  logic [N-1:0]     last_ready;
  int               n_checks = 0;
  int               n_pass   = 0;
  int               n_fail   = 0;
  int               fin_cnt  = 0;
  int               fin_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  task automatic push_src(input int u, input logic [AW-1:0] a);
    src_addr[u][src_cnt[u]] = a;
    src_cnt[u]++;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [IW-1:0] id);
    exp_q.push_back({a, id});
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_cnt[i]  = 0;
    end
    exp_q.delete();
  endtask

  // One clock: drive at the falling edge, sample one time unit after the rising edge.
  task automatic tick(input logic flush);
    logic [N-1:0]     acc;
    logic [AW+IW-1:0] e;
    @(negedge clk_i);
    flush_i = flush;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = (src_head[i] < src_cnt[i]);
      if (src_head[i] < src_cnt[i]) req_addr_i[i*AW +: AW] = src_addr[i][src_head[i]];
    end
    #1;
    last_ready = req_ready_o;
    acc        = req_valid_i & req_ready_o;
    @(posedge clk_i);
    #1;
    flush_i     = 1'b0;
    req_valid_i = '0;
    for (int i = 0; i < N; i++) if (acc[i]) src_head[i]++;
    if (finish_o === 1'b1) begin
      fin_cnt++;
      n_checks++;
      assert (exp_q.size() != 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL unexpected_finish: observed finish addr %0d id %0d, required no finish",
               finish_addr_o, grant_id_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("finish_addr", 32'(finish_addr_o), 32'(e[AW+IW-1:IW]));
        check("finish_id", 32'(grant_id_o), 32'(e[IW-1:0]));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_ni    = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = '0;
    clear_sources();
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_ni    = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = '0;
    req_addr_i  = '0;
    clear_sources();

    // Reset state
    #12;
    check("rst_finish", 32'(finish_o), 0);
    check("rst_addr", 32'(finish_addr_o), 0);
    check("rst_id", 32'(grant_id_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ready", 32'(req_ready_o), 0);
    check("rst_rr_ptr", 32'(dut.rr_ptr), 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    check("t1_ready_after_reset", 32'(req_ready_o), 32'hF);

    // 1) single completion on unit 0, two-edge latency
    push_src(0, 6'd5);
    push_exp(6'd5, 2'd0);
    tick(1'b0);
    check("t1_lat_edge1", 32'(finish_o), 0);
    check("t1_busy", 32'(busy_o), 1);
    tick(1'b0);
    check("t1_lat_edge2", 32'(finish_o), 1);
    tick(1'b0);
    check("t1_finish_drop", 32'(finish_o), 0);
    check("t1_idle_addr_hold", 32'(finish_addr_o), 5);

    // 2) all four units in one cycle from rr_ptr 0
    do_reset();
    for (int u = 0; u < N; u++) begin
      push_src(u, 6'(10 + u));
      push_exp(6'(10 + u), 2'(u));
    end
    tick(1'b0);
    check("t2_first_edge", 32'(finish_o), 0);
    for (int c = 0; c < 4; c++) begin
      tick(1'b0);
      check("t2_consecutive", 32'(finish_o), 1);
    end
    check("t2_rr_ptr_end", 32'(dut.rr_ptr), 0);
    tick(1'b0);
    check("t2_drained", 32'(finish_o), 0);

    // 3) units 1 and 3 streaming 8 each, alternating grants
    fin_base = fin_cnt;
    for (int k = 0; k < 8; k++) begin
      push_src(1, 6'(30 + k));
      push_src(3, 6'(40 + k));
      push_exp(6'(30 + k), 2'd1);
      push_exp(6'(40 + k), 2'd3);
    end
    tick(1'b0);
    check("t3_ready_start", 32'(last_ready), 32'hF);
    tick(1'b0);
    check("t3_ready_u3_waits", 32'(last_ready), 32'b0111);
    tick(1'b0);
    check("t3_ready_u1_waits", 32'(last_ready), 32'b1101);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick(1'b0);
    check("t3_scoreboard_empty", 32'(exp_q.size()), 0);
    check("t3_finish_count", 32'(fin_cnt - fin_base), 16);

    // 4) unit 2 alone, same-edge grant and refill
    for (int k = 0; k < 3; k++) begin
      push_src(2, 6'(20 + k));
      push_exp(6'(20 + k), 2'd2);
    end
    tick(1'b0);
    check("t4_ready_0", 32'(last_ready[2]), 1);
    for (int c = 0; c < 3; c++) begin
      tick(1'b0);
      if (c < 2) check("t4_ready_stream", 32'(last_ready[2]), 1);
      check("t4_finish_stream", 32'(finish_o), 1);
    end
    check("t4_scoreboard_empty", 32'(exp_q.size()), 0);

    // 5) flush with slots 0 and 2 pending; unit 1 offered during the flush cycle
    push_src(0, 6'd50);
    push_src(2, 6'd52);
    tick(1'b0);
    check("t5_busy_before", 32'(busy_o), 1);
    push_src(1, 6'd51);
    tick(1'b1);
    check("t5_ready_in_flush", 32'(last_ready), 0);
    check("t5_busy_after", 32'(busy_o), 0);
    check("t5_finish_after", 32'(finish_o), 0);
    check("t5_rr_ptr_kept", 32'(dut.rr_ptr), 3);
    src_head[1] = src_cnt[1];
    for (int c = 0; c < 3; c++) begin
      tick(1'b0);
      check("t5_nothing_later", 32'(finish_o), 0);
    end

    // 6) asynchronous reset in the middle of a burst
    push_src(0, 6'd60);
    push_src(1, 6'd61);
    push_src(2, 6'd62);
    push_exp(6'd60, 2'd0);
    tick(1'b0);
    tick(1'b0);
    check("t6_finish_before_reset", 32'(finish_o), 1);
    #2;
    reset_ni = 1'b0;
    #1;
    check("t6_finish_async", 32'(finish_o), 0);
    check("t6_busy_async", 32'(busy_o), 0);
    check("t6_ready_async", 32'(req_ready_o), 0);
    check("t6_addr_async", 32'(finish_addr_o), 0);
    check("t6_id_async", 32'(grant_id_o), 0);
    clear_sources();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    check("t6_rr_ptr_restart", 32'(dut.rr_ptr), 0);
    push_src(3, 6'd63);
    push_exp(6'd63, 2'd3);
    tick(1'b0);
    tick(1'b0);
    check("t6_finish_unit3", 32'(finish_o), 1);
    tick(1'b0);
    check("t6_scoreboard_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
